// File: rtl/profile_ci_pkg.sv
// Opcodes, command field offsets and STATUS layout shared by the
// profile_counter_bank_ci custom-instruction profiling unit.
package profile_ci_pkg;

  localparam logic [3:0] OP_READ_LO = 4'd0;
  localparam logic [3:0] OP_READ_HI = 4'd1;
  localparam logic [3:0] OP_CONTROL = 4'd2;
  localparam logic [3:0] OP_SELECT  = 4'd3;
  localparam logic [3:0] OP_STATUS  = 4'd4;

  // valueA layout
  localparam int OPCODE_LSB = 4;
  localparam int IDX_LSB    = 0;

  // CONTROL operand (valueB) fields, one bit per counter
  localparam int CTRL_SET_LSB  = 0;
  localparam int CTRL_CLR_LSB  = 8;
  localparam int CTRL_ZERO_LSB = 16;

  // STATUS result fields
  localparam int STAT_EN_LSB  = 0;
  localparam int STAT_OVF_LSB = 8;
  localparam int STAT_NUM_LSB = 16;

  typedef struct packed {
    logic       accept;
    logic [3:0] opcode;
    logic [2:0] idx;
    logic       idx_ok;
  } cmd_t;

  function automatic int sel_width(input int num_events);
    return (num_events > 1) ? $clog2(num_events) : 1;
  endfunction

endpackage

// File: rtl/profile_counter_bank_ci_if.sv
// Custom-instruction bus between the CPU (master) and the profiling unit (slave).
interface profile_counter_bank_ci_if;
  // start is a one-cycle strobe with no back-pressure; the slave answers a
  // command whose ciN matches its id with done=1 exactly one cycle later,
  // result being meaningful only while done=1 (0 otherwise).
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, ciN, valueA, valueB,
    input  done, result
  );

  modport slave (
    input  start, ciN, valueA, valueB,
    output done, result
  );
endinterface

// File: rtl/profile_event_counter.sv
// One profiling counter: event mux, enable, synchronous zero, wrap and, when
// PROFILE_CI_OVERFLOW_EN is defined, a sticky overflow flag.
module profile_event_counter
  import profile_ci_pkg::*;
#(
  parameter int W          = 32,
  parameter int NUM_EVENTS = 4,
  parameter int SEL_W      = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  zero,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NUM_EVENTS-1:0] events,
  output logic [W-1:0]          cnt,
  output logic                  ovf
);

  logic         ev;
  logic         hit;
  logic [W-1:0] cnt_q;

  // Select codes past the last event fall back to events[0].
  always_comb begin
    ev = events[0];
    for (int e = 0; e < NUM_EVENTS; e++) begin
      if (sel == SEL_W'(e)) ev = events[e];
    end
  end

  assign hit = en && ev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (zero) begin
      cnt_q <= '0;
    end else if (hit) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

`ifdef PROFILE_CI_OVERFLOW_EN
  logic wrap;
  logic ovf_q;

  assign wrap = hit && (cnt_q == '1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (zero) begin
      ovf_q <= 1'b0;
    end else if (wrap) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/profile_counter_bank_ci.sv
// Custom-instruction profiling unit: NUM_COUNTERS event counters controlled and
// read over the CI bus. Optional sticky overflow flags: PROFILE_CI_OVERFLOW_EN.
module profile_counter_bank_ci
  import profile_ci_pkg::*;
#(
  parameter logic [7:0] customId      = 8'h17,
  parameter int         NUM_COUNTERS  = 4,
  parameter int         COUNTER_WIDTH = 32,
  parameter int         NUM_EVENTS    = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_EVENTS-1:0]   events,
  profile_counter_bank_ci_if.slave bus
);

  localparam int N     = NUM_COUNTERS;
  localparam int SEL_W = sel_width(NUM_EVENTS);

  cmd_t                     cmd;
  logic                     ctrl_fire;
  logic [N-1:0]             set_m;
  logic [N-1:0]             clr_m;
  logic [N-1:0]             zero_m;
  logic [N-1:0]             en_q;
  logic [N-1:0]             en_new;
  logic [N-1:0]             en_eff;
  logic [N-1:0]             zero;
  logic [SEL_W-1:0]         sel_q [N];
  logic [COUNTER_WIDTH-1:0] cnt   [N];
  logic [N-1:0]             ovf;
  logic [63:0]              rd_cnt;
  logic [31:0]              snap_q;
  logic [31:0]              res_next;
  logic                     done_q;
  logic [31:0]              result_q;
  logic                     unused_bits;

  always_comb begin
    cmd.accept = bus.start && (bus.ciN == customId);
    cmd.opcode = bus.valueA[OPCODE_LSB +: 4];
    cmd.idx    = bus.valueA[IDX_LSB +: 3];
    cmd.idx_ok = int'({29'd0, cmd.idx}) < N;
  end

  assign ctrl_fire = cmd.accept && (cmd.opcode == OP_CONTROL);
  assign set_m     = bus.valueB[CTRL_SET_LSB  +: N];
  assign clr_m     = bus.valueB[CTRL_CLR_LSB  +: N];
  assign zero_m    = bus.valueB[CTRL_ZERO_LSB +: N];

  // Disable beats enable; the new mask already governs the accepting edge.
  assign en_new = (en_q | set_m) & ~clr_m;
  assign en_eff = ctrl_fire ? en_new : en_q;
  assign zero   = ctrl_fire ? zero_m : '0;

  for (genvar i = 0; i < N; i++) begin : g_cnt
    profile_event_counter #(
      .W          (COUNTER_WIDTH),
      .NUM_EVENTS (NUM_EVENTS),
      .SEL_W      (SEL_W)
    ) u_cnt (
      .clock  (clock),
      .reset  (reset),
      .en     (en_eff[i]),
      .zero   (zero[i]),
      .sel    (sel_q[i]),
      .events (events),
      .cnt    (cnt[i]),
      .ovf    (ovf[i])
    );
  end

  // Out-of-range indices match no counter and read as zero.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (cmd.idx == 3'(i)) rd_cnt = 64'(cnt[i]);
    end
  end

  always_comb begin
    res_next = '0;
    case (cmd.opcode)
      OP_READ_LO: res_next = rd_cnt[31:0];
      OP_READ_HI: res_next = cmd.idx_ok ? snap_q : 32'd0;
      OP_CONTROL: res_next[STAT_EN_LSB +: N] = en_new;
      OP_STATUS: begin
        res_next[STAT_EN_LSB  +: N] = en_q;
        res_next[STAT_OVF_LSB +: N] = ovf;
        res_next[STAT_NUM_LSB +: 8] = 8'(N);
      end
      default: res_next = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q     <= '0;
      snap_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      for (int i = 0; i < N; i++) sel_q[i] <= '0;
    end else begin
      done_q   <= cmd.accept;
      result_q <= cmd.accept ? res_next : 32'd0;
      if (ctrl_fire) en_q <= en_new;
      // Upper half is frozen with the low-half read so the pair stays coherent.
      if (cmd.accept && (cmd.opcode == OP_READ_LO)) snap_q <= rd_cnt[63:32];
      for (int i = 0; i < N; i++) begin
        if (cmd.accept && (cmd.opcode == OP_SELECT) && (cmd.idx == 3'(i))) begin
          sel_q[i] <= bus.valueB[SEL_W-1:0];
        end
      end
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

  assign unused_bits = ^{bus.valueA[31:8], bus.valueA[3], bus.valueB};

endmodule
